// File: rtl/ara_pkg.sv
// Helpers shared by the invalidation path: line-offset computation and the
// requester bundle type.
package ara_pkg;

  localparam int unsigned InvalAddrWidth = 64;

  typedef struct packed {
    logic [InvalAddrWidth-1:0] addr;
    logic                      valid;
  } inval_req_t;

  function automatic int unsigned inval_line_offset(input int unsigned l1_line_width);
    return $clog2(l1_line_width);
  endfunction

endpackage

// File: rtl/ara_inval_arbiter_rr.sv
// Round-robin arbiter with lock-in: a valid but unaccepted winner keeps the grant,
// and the priority pointer moves past the winner only when it is accepted.
module ara_inval_arbiter_rr #(
  parameter int unsigned NumIn     = 2,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumIn-1:0]                 req_i,
  input  logic [NumIn-1:0][DataWidth-1:0]  data_i,
  input  logic                             gnt_i,
  output logic [NumIn-1:0]                 gnt_o,
  output logic                             req_o,
  output logic [IdxWidth-1:0]              idx_o,
  output logic [DataWidth-1:0]             data_o
);

  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic                lock_q;
  logic                accept;

  always_comb begin : p_search
    int unsigned j;
    j     = 0;
    req_o = 1'b0;
    idx_o = '0;
    if (lock_q && req_i[lock_idx_q]) begin
      req_o = 1'b1;
      idx_o = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NumIn; i++) begin
        j = 32'(rr_q) + i;
        if (j >= NumIn) j = j - NumIn;
        if (!req_o && req_i[j]) begin
          req_o = 1'b1;
          idx_o = IdxWidth'(j);
        end
      end
    end
  end

  assign data_o = data_i[idx_o];
  assign accept = req_o && gnt_i;
  assign gnt_o  = accept ? (NumIn'(1) << idx_o) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (accept) begin
      rr_q   <= (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + IdxWidth'(1);
      lock_q <= 1'b0;
    end else begin
      lock_q     <= req_o;
      lock_idx_q <= idx_o;
    end
  end

endmodule

// File: rtl/ara_inval_arbiter.sv
// Arbitrates L1 D-cache invalidations onto CVA6's single port through a line FIFO.
// Define ARA_INVAL_COALESCE_EN to drop requests whose line is already queued.
module ara_inval_arbiter
  import ara_pkg::*;
#(
  parameter int unsigned NrPorts     = 2,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned FifoDepth   = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic [NrPorts-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NrPorts-1:0]                req_valid_i,
  output logic [NrPorts-1:0]                req_ready_o,
  output logic [AddrWidth-1:0]              inval_addr_o,
  output logic                              inval_valid_o,
  input  logic                              inval_ready_i,
  output logic                              busy_o
);

  localparam int unsigned LineOff  = inval_line_offset(L1LineWidth);
  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam logic [AddrWidth-1:0] LineMask =
      ~((AddrWidth'(1) << LineOff) - AddrWidth'(1));

  logic [AddrWidth-1:0] mem_q [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrWidth:0]    cnt_q;

  logic                 arb_req, arb_ready;
  logic [AddrWidth-1:0] arb_addr, line;
  logic                 full, empty, pop, push, hit, accept;

  ara_inval_arbiter_rr #(
    .NumIn     (NrPorts),
    .DataWidth (AddrWidth)
  ) i_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_valid_i),
    .data_i (req_addr_i),
    .gnt_i  (arb_ready),
    .gnt_o  (req_ready_o),
    .req_o  (arb_req),
    .idx_o  (),
    .data_o (arb_addr)
  );

  assign line      = arb_addr & LineMask;
  assign full      = (cnt_q == (PtrWidth+1)'(FifoDepth));
  assign empty     = (cnt_q == '0);
  assign pop       = !empty && inval_ready_i;
  assign arb_ready = !en_i || !full || pop || hit;
  assign accept    = arb_req && arb_ready;
  // With coherence off the request is acknowledged but never queued.
  assign push      = accept && en_i && !hit;

`ifdef ARA_INVAL_COALESCE_EN
  logic [FifoDepth-1:0] ent_v_q;

  // The head leaving this cycle must not absorb a newer write to the same line.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < FifoDepth; i++) begin
      if (ent_v_q[i] && (mem_q[i] == line) && !(pop && (PtrWidth'(i) == rd_ptr_q))) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_v_q <= '0;
    end else begin
      if (pop)  ent_v_q[rd_ptr_q] <= 1'b0;
      if (push) ent_v_q[wr_ptr_q] <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= line;
        wr_ptr_q        <= wr_ptr_q + PtrWidth'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      if (push && !pop) begin
        cnt_q <= cnt_q + (PtrWidth+1)'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - (PtrWidth+1)'(1);
      end
    end
  end

  assign inval_valid_o = !empty;
  assign busy_o        = !empty;
  assign inval_addr_o  = mem_q[rd_ptr_q];

endmodule
